// File: rtl/cc_pkg.sv
// Shared types and constants for the cache-controller miss handler.
package cc_pkg;

    // Lifecycle of one miss-status-holding entry
    typedef enum logic [2:0] {
        ST_FREE   = 3'd0,
        ST_PEND   = 3'd1,
        ST_ISSUED = 3'd2,
        ST_FILL   = 3'd3,
        ST_WRITE  = 3'd4
    } mshr_state_e;

    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Number of R beats needed to fill one line
    function automatic int cc_line_beats(input int line_b, input int data_w);
        return (line_b * 8) / data_w;
    endfunction

endpackage

// File: rtl/cc_mshr_entry.sv
// One MSHR entry: state, line address, critical word, beat counter, line buffer.
module cc_mshr_entry
    import cc_pkg::*;
#(
    parameter int LA_W   = 26,
    parameter int CW_W   = 3,
    parameter int DATA_W = 64,
    parameter int BEATS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_alloc,
    input  logic [LA_W-1:0]              i_line,
    input  logic [CW_W-1:0]              i_crit,
    input  logic                         i_ar_done,
    input  logic                         i_beat,
    input  logic                         i_rlast,
    input  logic [DATA_W-1:0]            i_rdata,
    output mshr_state_e                  o_state,
    output logic [LA_W-1:0]              o_line,
    output logic [CW_W-1:0]              o_crit,
    output logic [CW_W-1:0]              o_cnt,
    output logic [BEATS-1:0][DATA_W-1:0] o_data
);

    mshr_state_e                  r_state;
    logic [LA_W-1:0]              r_line;
    logic [CW_W-1:0]              r_crit;
    logic [CW_W-1:0]              r_cnt;
    logic [BEATS-1:0][DATA_W-1:0] r_data;
    logic                         w_take;
    logic [CW_W-1:0]              w_slot;

    // Beats are only meaningful once the AR has gone out
    assign w_take = i_beat && (r_state == ST_ISSUED || r_state == ST_FILL);
    // Wrap burst starts at the critical word; counter wraps naturally at BEATS
    assign w_slot = r_crit + r_cnt;

    // Entry lifecycle and bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FREE;
            r_line  <= '0;
            r_crit  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_FREE: if (i_alloc) begin
                    r_state <= ST_PEND;
                    r_line  <= i_line;
                    r_crit  <= i_crit;
                    r_cnt   <= '0;
                end
                ST_PEND: if (i_ar_done) r_state <= ST_ISSUED;
                ST_ISSUED, ST_FILL: if (w_take) begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= i_rlast ? ST_WRITE : ST_FILL;
                end
                default: r_state <= ST_FREE;
            endcase
        end
    end

    // Line buffer; contents are only consumed while the entry is in WRITE
    always_ff @(posedge clk) begin
        if (w_take) r_data[w_slot] <= i_rdata;
    end

    assign o_state = r_state;
    assign o_line  = r_line;
    assign o_crit  = r_crit;
    assign o_cnt   = r_cnt;
    assign o_data  = r_data;

endmodule

// File: rtl/cc_miss_handler.sv
// Multi-entry miss handler: merges secondary misses, issues WRAP bursts,
// reassembles out-of-order R beats by ID and writes completed lines out.
module cc_miss_handler
    import cc_pkg::*;
#(
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 64,
    parameter  int LINE_B   = 64,
    parameter  int INDEX_W  = 9,
    parameter  int NUM_MSHR = 4,
    parameter  int ID_W     = 4,
    localparam int BEATS    = cc_line_beats(LINE_B, DATA_W),
    localparam int OFF_W    = $clog2(LINE_B),
    localparam int WB_W     = $clog2(DATA_W / 8),
    localparam int CW_W     = $clog2(BEATS),
    localparam int LA_W     = ADDR_W - OFF_W,
    localparam int TAG_W    = LA_W - INDEX_W,
    localparam int IW       = $clog2(NUM_MSHR)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                miss_valid_i,
    input  logic [ADDR_W-1:0]   miss_addr_i,
    output logic                miss_ready_o,
    output logic                merge_o,
    output logic [IW-1:0]       miss_id_o,
    output logic [ID_W-1:0]     mem_arid_o,
    output logic [ADDR_W-1:0]   mem_araddr_o,
    output logic [3:0]          mem_arlen_o,
    output logic [2:0]          mem_arsize_o,
    output logic [1:0]          mem_arburst_o,
    output logic                mem_arvalid_o,
    input  logic                mem_arready_i,
    input  logic [ID_W-1:0]     mem_rid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic [1:0]          mem_rresp_i,
    input  logic                mem_rlast_i,
    input  logic                mem_rvalid_i,
    output logic                mem_rready_o,
    output logic                wren_o,
    output logic [INDEX_W-1:0]  waddr_o,
    output logic [TAG_W:0]      wdata_tag_o,
    output logic [LINE_B*8-1:0] wdata_data_o,
    output logic [IW-1:0]       fill_id_o,
    output logic                err_o
);

    mshr_state_e                            w_state [NUM_MSHR];
    logic [NUM_MSHR-1:0][LA_W-1:0]          w_line;
    logic [NUM_MSHR-1:0][CW_W-1:0]          w_crit;
    logic [NUM_MSHR-1:0][CW_W-1:0]          w_cnt;
    logic [NUM_MSHR-1:0][BEATS*DATA_W-1:0]  w_data;

    logic [LA_W-1:0] w_req_line;
    logic [CW_W-1:0] w_req_crit;
    logic            w_unused_lsb;
    logic            w_hit, w_free, w_pend, w_acc;
    logic [IW-1:0]   w_hit_idx, w_free_idx, w_pend_idx, w_ar_idx, w_rid_idx;
    logic            w_ar_fire, w_rbeat, w_rid_ok, w_rtake, w_last_bad;
    logic            r_ar_hold, r_wren, r_err;
    logic [IW-1:0]   r_ar_idx, r_fill_id;

    assign w_req_line   = miss_addr_i[ADDR_W-1:OFF_W];
    assign w_req_crit   = miss_addr_i[OFF_W-1:WB_W];
    assign w_unused_lsb = ^miss_addr_i[WB_W-1:0];

    // Match, free and pending priority encoders; descending scan so lowest index wins
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_pend     = 1'b0;
        w_pend_idx = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (w_state[i] != ST_FREE && w_line[i] == w_req_line) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
            if (w_state[i] == ST_FREE) begin
                w_free     = 1'b1;
                w_free_idx = IW'(i);
            end
            if (w_state[i] == ST_PEND) begin
                w_pend     = 1'b1;
                w_pend_idx = IW'(i);
            end
        end
    end

    // Request side: a hit always merges, otherwise a free entry is needed
    assign miss_ready_o = !rst && (w_hit || w_free);
    assign w_acc        = miss_valid_i && miss_ready_o;
    assign merge_o      = w_acc && w_hit;
    assign miss_id_o    = !w_acc ? '0 : (w_hit ? w_hit_idx : w_free_idx);

    // AR: once presented, the chosen entry is held until accepted, even if a
    // lower-index entry becomes pending in the meantime
    assign w_ar_idx      = r_ar_hold ? r_ar_idx : w_pend_idx;
    assign mem_arvalid_o = w_pend;
    assign w_ar_fire     = mem_arvalid_o && mem_arready_i;
    assign mem_arid_o    = mem_arvalid_o ? ID_W'(w_ar_idx) : '0;
    assign mem_araddr_o  = mem_arvalid_o ? {w_line[w_ar_idx], w_crit[w_ar_idx], {WB_W{1'b0}}} : '0;
    assign mem_arlen_o   = mem_arvalid_o ? 4'(BEATS - 1) : '0;
    assign mem_arsize_o  = mem_arvalid_o ? 3'(WB_W) : '0;
    assign mem_arburst_o = mem_arvalid_o ? AXI_BURST_WRAP : '0;

    // Remember a stalled AR selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ar_hold <= 1'b0;
            r_ar_idx  <= '0;
        end else begin
            r_ar_hold <= mem_arvalid_o && !mem_arready_i;
            r_ar_idx  <= w_ar_idx;
        end
    end

    // R side: beats for an id without an issued entry are dropped
    assign mem_rready_o = !rst;
    assign w_rbeat      = mem_rvalid_i && mem_rready_o;
    assign w_rid_idx    = mem_rid_i[IW-1:0];
    assign w_rid_ok     = (32'(mem_rid_i) < NUM_MSHR) &&
                          (w_state[w_rid_idx] == ST_ISSUED || w_state[w_rid_idx] == ST_FILL);
    assign w_rtake      = w_rbeat && w_rid_ok;
    assign w_last_bad   = mem_rlast_i && (w_cnt[w_rid_idx] != CW_W'(BEATS - 1));

    for (genvar g = 0; g < NUM_MSHR; g++) begin : g_mshr
        cc_mshr_entry #(
            .LA_W   (LA_W),
            .CW_W   (CW_W),
            .DATA_W (DATA_W),
            .BEATS  (BEATS)
        ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .i_alloc   (w_acc && !w_hit && w_free_idx == IW'(g)),
            .i_line    (w_req_line),
            .i_crit    (w_req_crit),
            .i_ar_done (w_ar_fire && w_ar_idx == IW'(g)),
            .i_beat    (w_rtake && w_rid_idx == IW'(g)),
            .i_rlast   (mem_rlast_i),
            .i_rdata   (mem_rdata_i),
            .o_state   (w_state[g]),
            .o_line    (w_line[g]),
            .o_crit    (w_crit[g]),
            .o_cnt     (w_cnt[g]),
            .o_data    (w_data[g])
        );
    end

    // Sticky error: bad id, non-OKAY response, or short/long burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else if (w_rbeat && (!w_rid_ok || mem_rresp_i != AXI_RESP_OKAY || (w_rid_ok && w_last_bad)))
            r_err <= 1'b1;
    end

    // Write-out register: the entry sits in WRITE during the cycle wren_o is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wren    <= 1'b0;
            r_fill_id <= '0;
        end else begin
            r_wren    <= w_rtake && mem_rlast_i;
            r_fill_id <= w_rid_idx;
        end
    end

    assign wren_o       = r_wren;
    assign fill_id_o    = r_wren ? r_fill_id : '0;
    assign waddr_o      = r_wren ? w_line[r_fill_id][INDEX_W-1:0] : '0;
    assign wdata_tag_o  = r_wren ? {1'b1, w_line[r_fill_id][LA_W-1:INDEX_W]} : '0;
    assign wdata_data_o = r_wren ? w_data[r_fill_id] : '0;
    assign err_o        = r_err;

endmodule

// File: tb/tb_cc_miss_handler.sv
// Scoreboard bench for cc_miss_handler: stimulus pushes expectations,
// a negedge monitor pops them as accepts, ARs and line writes appear.
module tb_cc_miss_handler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_valid = 1'b0;
    logic [31:0]  miss_addr = '0;
    logic         miss_ready_o, merge_o;
    logic [1:0]   miss_id_o;
    logic [3:0]   mem_arid_o;
    logic [31:0]  mem_araddr_o;
    logic [3:0]   mem_arlen_o;
    logic [2:0]   mem_arsize_o;
    logic [1:0]   mem_arburst_o;
    logic         mem_arvalid_o;
    logic         ar_rdy = 1'b1;
    logic [3:0]   rid = '0;
    logic [63:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         mem_rready_o, wren_o, err_o;
    logic [8:0]   waddr_o;
    logic [17:0]  wdata_tag_o;
    logic [511:0] wdata_data_o;
    logic [1:0]   fill_id_o;

    always #5 clk = ~clk;

    cc_miss_handler dut (
        .clk(clk), .rst(rst),
        .miss_valid_i(miss_valid), .miss_addr_i(miss_addr), .miss_ready_o(miss_ready_o),
        .merge_o(merge_o), .miss_id_o(miss_id_o),
        .mem_arid_o(mem_arid_o), .mem_araddr_o(mem_araddr_o), .mem_arlen_o(mem_arlen_o),
        .mem_arsize_o(mem_arsize_o), .mem_arburst_o(mem_arburst_o),
        .mem_arvalid_o(mem_arvalid_o), .mem_arready_i(ar_rdy),
        .mem_rid_i(rid), .mem_rdata_i(rdata), .mem_rresp_i(rresp), .mem_rlast_i(rlast),
        .mem_rvalid_i(rvalid), .mem_rready_o(mem_rready_o),
        .wren_o(wren_o), .waddr_o(waddr_o), .wdata_tag_o(wdata_tag_o),
        .wdata_data_o(wdata_data_o), .fill_id_o(fill_id_o), .err_o(err_o)
    );

    typedef struct packed { logic m; logic [1:0] id; }        acc_t;
    typedef struct packed { logic [3:0] id; logic [31:0] a; } ar_t;
    typedef struct packed { logic [1:0] id; logic [25:0] ln; } wr_t;

    acc_t q_acc[$];
    ar_t  q_ar[$];
    wr_t  q_wr[$];
    int   vec = 0;
    int   bad = 0;

    logic [31:0] la [4] = '{32'h0002_0000, 32'h0003_1238, 32'h1234_5670, 32'hFFFF_FFC0};
    logic [31:0] lb [5] = '{32'h0000_2000, 32'h0000_2040, 32'h0000_2080, 32'h0000_20C0, 32'h0000_2100};
    int          ord[4] = '{3, 1, 0, 2};

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Beat payload: tagged with line address and word slot so misplacement is visible
    function automatic logic [63:0] mk(input logic [25:0] ln, input int slot);
        return {8'hA5, 8'(slot), 22'h0, ln};
    endfunction

    function automatic logic [511:0] exp_line(input logic [25:0] ln);
        logic [511:0] r;
        for (int w = 0; w < 8; w++) r[w*64 +: 64] = mk(ln, w);
        return r;
    endfunction

    // Monitor
    always @(negedge clk) begin
        acc_t ea;
        ar_t  er;
        wr_t  ew;
        if (!rst) begin
            if (miss_valid && miss_ready_o) begin
                if (q_acc.size() == 0) chk("acc_unexpected", 1, 0);
                else begin
                    ea = q_acc.pop_front();
                    chk("merge", merge_o, ea.m);
                    chk("miss_id", miss_id_o, ea.id);
                end
            end
            if (mem_arvalid_o) begin
                if (q_ar.size() == 0) chk("ar_unexpected", 1, 0);
                else begin
                    er = q_ar[0];
                    chk("arid", mem_arid_o, er.id);
                    chk("araddr", mem_araddr_o, er.a);
                    chk("arlen", mem_arlen_o, 7);
                    chk("arsize", mem_arsize_o, 3);
                    chk("arburst", mem_arburst_o, 2);
                    if (ar_rdy) void'(q_ar.pop_front());
                end
            end
            if (wren_o) begin
                if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    ew = q_wr.pop_front();
                    chk("fill_id", fill_id_o, ew.id);
                    chk("waddr", waddr_o, ew.ln[8:0]);
                    chk("wtag", wdata_tag_o, {1'b1, ew.ln[25:9]});
                    chk("wdata", wdata_data_o, exp_line(ew.ln));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input logic [31:0] a, input logic m, input logic [1:0] id);
        q_acc.push_back({m, id});
        miss_valid = 1'b1;
        miss_addr  = a;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (miss_ready_o) begin
                tick();
                miss_valid = 1'b0;
                return;
            end
            tick();
        end
        miss_valid = 1'b0;
        void'(q_acc.pop_back());
        chk("miss_timeout", 1, 0);
    endtask

    task automatic beat(input logic [3:0] id, input logic [63:0] d, input logic [1:0] rs, input logic last);
        rid = id; rdata = d; rresp = rs; rlast = last; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic send_line(input logic [1:0] id, input logic [31:0] a, input int bad_k);
        logic [2:0] s;
        q_wr.push_back({id, a[31:6]});
        for (int k = 0; k < 8; k++) begin
            s = a[5:3] + 3'(k);
            beat({2'b00, id}, mk(a[31:6], int'(s)), (k == bad_k) ? 2'b10 : 2'b00, k == 7);
        end
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        while ((q_ar.size() != 0 || q_wr.size() != 0) && t < 100) begin
            tick();
            t++;
        end
        chk(nm, q_ar.size() + q_wr.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_rready", mem_rready_o, 0);
        chk("rst_mready", miss_ready_o, 0);
        chk("rst_arvalid", mem_arvalid_o, 0);
        chk("rst_wren", wren_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_wdata", wdata_data_o, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_rready", mem_rready_o, 1);
        chk("rdy_mready", miss_ready_o, 1);
        tick();

        // Single miss, critical word 1, hand-checked index and tag
        q_ar.push_back({4'd0, 32'h0000_1048});
        miss(32'h0000_1048, 1'b0, 2'd0);
        wait_idle("t1_ar");
        send_line(2'd0, 32'h0000_1048, -1);
        @(negedge clk);
        chk("t1_wren", wren_o, 1);
        chk("t1_waddr", waddr_o, 9'h041);
        chk("t1_tag", wdata_tag_o, 18'h20000);
        chk("t1_word1", wdata_data_o[127:64], 64'hA501_0000_0000_0041);
        tick();
        wait_idle("t1_wr");
        chk("t1_err", err_o, 0);

        // Secondary miss to the same line merges, one AR only
        q_ar.push_back({4'd0, 32'h0000_1048});
        miss(32'h0000_1048, 1'b0, 2'd0);
        miss(32'h0000_1070, 1'b1, 2'd0);
        wait_idle("t2_ar");
        send_line(2'd0, 32'h0000_1048, -1);
        wait_idle("t2_wr");

        // Four lines, R returned interleaved with ids 3,1,0,2
        for (int i = 0; i < 4; i++) begin
            q_ar.push_back({4'(i), la[i] & 32'hFFFF_FFF8});
            miss(la[i], 1'b0, 2'(i));
        end
        wait_idle("t3_ar");
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                logic [31:0] a;
                logic [2:0]  s;
                a = la[ord[j]];
                s = a[5:3] + 3'(k);
                if (k == 7) q_wr.push_back({2'(ord[j]), a[31:6]});
                beat(4'(ord[j]), mk(a[31:6], int'(s)), 2'b00, k == 7);
            end
        end
        wait_idle("t3_wr");
        chk("t3_err", err_o, 0);

        // Fifth distinct line stalls until the cycle after the first write
        for (int i = 0; i < 4; i++) begin
            q_ar.push_back({4'(i), lb[i]});
            miss(lb[i], 1'b0, 2'(i));
        end
        wait_idle("t4_ar");
        miss_valid = 1'b1;
        miss_addr  = lb[4];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_full", miss_ready_o, 0);
            tick();
        end
        q_acc.push_back({1'b0, 2'd0});
        q_ar.push_back({4'd0, lb[4]});
        send_line(2'd0, lb[0], -1);
        @(negedge clk);
        chk("t4_wren", wren_o, 1);
        chk("t4_busy_in_write", miss_ready_o, 0);
        tick();
        @(negedge clk);
        chk("t4_freed", miss_ready_o, 1);
        tick();
        miss_valid = 1'b0;
        wait_idle("t4_ar5");
        send_line(2'd1, lb[1], -1);
        send_line(2'd2, lb[2], -1);
        send_line(2'd3, lb[3], -1);
        send_line(2'd0, lb[4], -1);
        wait_idle("t4_wr");
        chk("t4_err", err_o, 0);

        // AR stalled five cycles, then SLVERR on one beat
        ar_rdy = 1'b0;
        q_ar.push_back({4'd0, 32'h0000_5238});
        miss(32'h0000_5238, 1'b0, 2'd0);
        repeat (5) tick();
        @(negedge clk);
        chk("t5_arvalid_held", mem_arvalid_o, 1);
        tick();
        ar_rdy = 1'b1;
        wait_idle("t5_ar");
        send_line(2'd0, 32'h0000_5238, 3);
        wait_idle("t5_wr");
        chk("t5_err", err_o, 1);

        // Reset clears err; beat with unknown id is dropped and flags err
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_err_clr", err_o, 0);
        tick();
        beat(4'd7, 64'hDEAD, 2'b00, 1'b1);
        chk("t6_err_rid", err_o, 1);

        // Reset in the middle of a burst
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q_ar.push_back({4'd0, 32'h0000_1048});
        miss(32'h0000_1048, 1'b0, 2'd0);
        wait_idle("t7_ar");
        for (int k = 0; k < 3; k++) beat(4'd0, mk(26'h41, k + 1), 2'b00, 1'b0);
        rst = 1'b1;
        #1;
        chk("t7_wren", wren_o, 0);
        chk("t7_arvalid", mem_arvalid_o, 0);
        chk("t7_rready", mem_rready_o, 0);
        chk("t7_mready", miss_ready_o, 0);
        chk("t7_err", err_o, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t7_mready_after", miss_ready_o, 1);
        tick();
        beat(4'd0, 64'h1, 2'b00, 1'b1);
        chk("t7_stale_err", err_o, 1);
        q_ar.push_back({4'd0, 32'h0000_1048});
        miss(32'h0000_1048, 1'b0, 2'd0);
        wait_idle("t7_realloc");
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
